// File: rtl/jt7759_seq.sv
`default_nettype none
// ============================================================================
// Module   : jt7759_seq
// Purpose  : Phrase sequencer for the JT7759 ADPCM path. On a host start it
//            reads the phrase pointer from the ROM header, then walks the
//            phrase command stream, pulling bytes through the data-FIFO
//            control interface and handing nibbles to the ADPCM decoder.
// Ports    : i_clk, i_rstn        clock, async active-low reset
//            i_cen_ctl            control clock enable (shared with FIFO)
//            i_cen_dec            decoder sample strobe, one nibble per tick
//            i_st, i_phrase       host start pulse and phrase number
//            o_busyn, o_err       host status
//            o_ctrl_busyn         high flushes FIFO, falling edge loads addr
//            o_ctrl_addr          ROM byte address for the next fetch run
//            o_ctrl_cs            byte request; i_ctrl_ok/i_ctrl_din answer
//            o_dec_rst            decoder state reset
//            o_dec_en, o_dec_nibble  one-clk nibble strobe and nibble
// Revision : 1.0 - initial release
// ============================================================================
module jt7759_seq #(
  parameter int SIL_UNIT  = 32,  // cen_dec ticks per silence unit
  parameter int JUMP_HOLD = 2    // cen_ctl ticks ctrl_busyn held high on a jump
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_cen_ctl,
  input  logic        i_cen_dec,
  input  logic        i_st,
  input  logic [7:0]  i_phrase,
  output logic        o_busyn,
  output logic        o_err,
  output logic        o_ctrl_busyn,
  output logic [16:0] o_ctrl_addr,
  output logic        o_ctrl_cs,
  input  logic [7:0]  i_ctrl_din,
  input  logic        i_ctrl_ok,
  output logic        o_dec_rst,
  output logic        o_dec_en,
  output logic [3:0]  o_dec_nibble
);

  localparam logic [2:0] c_ST_IDLE = 3'd0;
  localparam logic [2:0] c_ST_JMP  = 3'd1;
  localparam logic [2:0] c_ST_HDR  = 3'd2;
  localparam logic [2:0] c_ST_PTR  = 3'd3;
  localparam logic [2:0] c_ST_CMD  = 3'd4;
  localparam logic [2:0] c_ST_LEN  = 3'd5;
  localparam logic [2:0] c_ST_SIL  = 3'd6;
  localparam logic [2:0] c_ST_PLAY = 3'd7;

  // Silence counter must hold 63*SIL_UNIT; never narrower than 12 bits.
  localparam int c_SIL_BITS = $clog2(63 * SIL_UNIT + 1);
  localparam int c_SW = (c_SIL_BITS > 12) ? c_SIL_BITS : 12;
  localparam int c_HW = (JUMP_HOLD > 1) ? $clog2(JUMP_HOLD) : 1;
  localparam logic [c_HW-1:0] c_HOLD_LAST = c_HW'(JUMP_HOLD - 1);

  logic [2:0]      r_state, w_state_nxt;
  logic [2:0]      r_jret, w_jret;
  logic            w_jump;
  logic [16:0]     w_jaddr;
  logic            w_take, w_issue, w_want;
  logic            w_busyn, w_ctrl_busyn;

  logic [7:0]      r_phrase;
  logic            r_err;
  logic [16:0]     r_addr;
  logic            r_cs;
  logic [c_HW-1:0] r_hold;
  logic [7:0]      r_ptr_hi;
  logic            r_ptr_lo;
  logic [8:0]      r_cnt;
  logic [c_SW-1:0] r_sil;
  logic [c_SW-1:0] w_sil_load;
  logic [7:0]      r_buf;
  logic            r_bvalid;
  logic            r_lo;
  logic            r_dec_rst;
  logic            r_dec_en;
  logic [3:0]      r_dec_nib;

  assign w_take     = r_cs & i_ctrl_ok;
  assign w_issue    = (r_state == c_ST_PLAY) & i_cen_dec & r_bvalid;
  assign w_sil_load = c_SW'(i_ctrl_din[5:0]) * c_SW'(SIL_UNIT);

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) r_state <= c_ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // --------------------------------------------------------------- next state
  // A jump always detours through JMP, which returns to w_jret once the
  // FIFO flush hold has elapsed. A host start overrides everything else.
  always_comb begin
    w_state_nxt = r_state;
    w_jump      = 1'b0;
    w_jaddr     = r_addr;
    w_jret      = r_jret;
    if (i_st) begin
      w_jump  = 1'b1;
      w_jaddr = 17'd0;
      w_jret  = c_ST_HDR;
    end else begin
      case (r_state)
        c_ST_JMP:
          if (i_cen_ctl && (r_hold == c_HOLD_LAST)) w_state_nxt = r_jret;
        c_ST_HDR:
          if (w_take) begin
            if (r_phrase > i_ctrl_din) begin
              w_state_nxt = c_ST_IDLE;
            end else begin
              w_jump  = 1'b1;
              w_jaddr = 17'd5 + {8'd0, r_phrase, 1'b0};
              w_jret  = c_ST_PTR;
            end
          end
        c_ST_PTR:
          if (w_take && r_ptr_lo) begin
            w_jump  = 1'b1;
            w_jaddr = {r_ptr_hi, i_ctrl_din, 1'b0};
            w_jret  = c_ST_CMD;
          end
        c_ST_CMD:
          if (w_take) begin
            case (i_ctrl_din[7:6])
              2'b00:   w_state_nxt = (i_ctrl_din[5:0] == 6'd0) ? c_ST_IDLE : c_ST_SIL;
              2'b01:   w_state_nxt = c_ST_PLAY;
              2'b10:   w_state_nxt = c_ST_LEN;
              default: w_state_nxt = c_ST_IDLE;
            endcase
          end
        c_ST_LEN:
          if (w_take) w_state_nxt = c_ST_PLAY;
        c_ST_SIL:
          if (i_cen_dec && (r_sil == c_SW'(1))) w_state_nxt = c_ST_CMD;
        c_ST_PLAY:
          if (w_issue && (r_cnt == 9'd1)) w_state_nxt = c_ST_CMD;
        default: ;
      endcase
    end
    if (w_jump) w_state_nxt = c_ST_JMP;
  end

  // ------------------------------------------------------------------ outputs
  // In PLAY a new byte is requested only once the buffer has been fully
  // consumed, so no byte past the last needed nibble is ever fetched.
  always_comb begin
    w_busyn      = (r_state == c_ST_IDLE);
    w_ctrl_busyn = (r_state == c_ST_IDLE) || (r_state == c_ST_JMP);
    w_want       = 1'b0;
    case (r_state)
      c_ST_HDR, c_ST_PTR, c_ST_CMD, c_ST_LEN: w_want = 1'b1;
      c_ST_PLAY:                              w_want = ~r_bvalid;
      default:                                w_want = 1'b0;
    endcase
  end

  assign o_busyn      = w_busyn;
  assign o_ctrl_busyn = w_ctrl_busyn;
  assign o_err        = r_err;
  assign o_ctrl_addr  = r_addr;
  assign o_ctrl_cs    = r_cs;
  assign o_dec_rst    = r_dec_rst;
  assign o_dec_en     = r_dec_en;
  assign o_dec_nibble = r_dec_nib;

  // ----------------------------------------------------------------- datapath
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_phrase  <= 8'd0;
      r_err     <= 1'b0;
      r_addr    <= 17'd0;
      r_cs      <= 1'b0;
      r_hold    <= '0;
      r_jret    <= c_ST_IDLE;
      r_ptr_hi  <= 8'd0;
      r_ptr_lo  <= 1'b0;
      r_cnt     <= 9'd0;
      r_sil     <= '0;
      r_buf     <= 8'd0;
      r_bvalid  <= 1'b0;
      r_lo      <= 1'b0;
      r_dec_rst <= 1'b1;
      r_dec_en  <= 1'b0;
      r_dec_nib <= 4'd0;
    end else begin
      r_dec_en <= 1'b0;

      if (w_jump) begin
        r_addr   <= w_jaddr;
        r_hold   <= '0;
        r_jret   <= w_jret;
        r_ptr_lo <= 1'b0;
      end else if ((r_state == c_ST_JMP) && i_cen_ctl) begin
        r_hold <= r_hold + c_HW'(1);
      end

      if (i_st) begin
        r_phrase  <= i_phrase;
        r_err     <= 1'b0;
        r_cs      <= 1'b0;
        r_bvalid  <= 1'b0;
        r_dec_rst <= 1'b1;
      end else begin
        // Dropping cs on capture and re-raising only from a low cs gives
        // at least one idle clk between requests.
        if (w_take)      r_cs <= 1'b0;
        else if (w_want) r_cs <= 1'b1;

        case (r_state)
          c_ST_HDR:
            if (w_take && (r_phrase > i_ctrl_din)) r_err <= 1'b1;
          c_ST_PTR:
            if (w_take && !r_ptr_lo) begin
              r_ptr_hi <= i_ctrl_din;
              r_ptr_lo <= 1'b1;
            end
          c_ST_CMD:
            if (w_take) begin
              r_bvalid <= 1'b0;
              r_lo     <= 1'b0;
              case (i_ctrl_din[7:6])
                2'b00: begin
                  r_sil     <= w_sil_load;
                  r_dec_rst <= 1'b1;
                end
                2'b01: begin
                  r_cnt     <= 9'd256;
                  r_dec_rst <= 1'b0;
                end
                2'b10:   r_dec_rst <= 1'b0;
                default: r_dec_rst <= 1'b1;
              endcase
            end
          c_ST_LEN:
            if (w_take) r_cnt <= {1'b0, i_ctrl_din} + 9'd1;
          c_ST_SIL:
            if (i_cen_dec) r_sil <= r_sil - c_SW'(1);
          c_ST_PLAY: begin
            // A byte captured on a cen_dec clk is only seen by the next
            // tick because w_issue looks at the old r_bvalid.
            if (w_take) begin
              r_buf    <= i_ctrl_din;
              r_bvalid <= 1'b1;
              r_lo     <= 1'b0;
            end
            if (w_issue) begin
              r_dec_en  <= 1'b1;
              r_dec_nib <= r_lo ? r_buf[3:0] : r_buf[7:4];
              r_cnt     <= r_cnt - 9'd1;
              r_lo      <= ~r_lo;
              // last nibble of the run drops any unused low nibble
              if (r_lo || (r_cnt == 9'd1)) r_bvalid <= 1'b0;
            end
          end
          default: ;
        endcase

        if ((w_state_nxt == c_ST_IDLE) && (r_state != c_ST_IDLE)) begin
          r_dec_rst <= 1'b1;
          r_cs      <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_jt7759_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_jt7759_seq
// Purpose  : Directed self-checking bench for jt7759_seq with a ROM-backed
//            FIFO model and hand-computed expected values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jt7759_seq;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cen_ctl = 1'b0;
  logic        cen_dec = 1'b0;
  logic        st = 1'b0;
  logic [7:0]  phrase = 8'd0;
  logic        stall = 1'b0;
  logic        sil_arm = 1'b0;

  logic        busyn, err, ctrl_busyn, ctrl_cs, dec_rst, dec_en;
  logic [16:0] ctrl_addr;
  logic [3:0]  dec_nibble;
  logic        ctrl_ok;
  logic [7:0]  ctrl_din;

  logic [7:0]  rom [0:1023];
  logic [16:0] fptr = 17'd0;
  int          fetch_cnt = 0;
  int          en_cnt = 0;
  int          tick_cnt = 0;
  int          sil_ticks = 0;
  logic        seen_play = 1'b0;
  logic        prev_cbusy = 1'b1;
  logic [16:0] addr_q[$];
  logic [3:0]  nib_q[$];
  int          tick_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  jt7759_seq #(.SIL_UNIT(32), .JUMP_HOLD(2)) u_dut (
    .i_clk        (clk),
    .i_rstn       (rstn),
    .i_cen_ctl    (cen_ctl),
    .i_cen_dec    (cen_dec),
    .i_st         (st),
    .i_phrase     (phrase),
    .o_busyn      (busyn),
    .o_err        (err),
    .o_ctrl_busyn (ctrl_busyn),
    .o_ctrl_addr  (ctrl_addr),
    .o_ctrl_cs    (ctrl_cs),
    .i_ctrl_din   (ctrl_din),
    .i_ctrl_ok    (ctrl_ok),
    .o_dec_rst    (dec_rst),
    .o_dec_en     (dec_en),
    .o_dec_nibble (dec_nibble)
  );

  initial forever #5 clk = ~clk;

  // cen_ctl every 2 clk, cen_dec every 8 clk
  initial begin
    int div;
    div = 0;
    forever begin
      @(posedge clk);
      #1;
      div++;
      cen_ctl = (div % 2) == 0;
      cen_dec = (div % 8) == 0;
    end
  end

  // FIFO model: address reloads while ctrl_busyn is high, bytes answered at once
  assign ctrl_ok  = ctrl_cs & ~ctrl_busyn & ~stall;
  assign ctrl_din = rom[fptr[9:0]];

  always @(posedge clk) begin
    if (ctrl_busyn) fptr <= ctrl_addr;
    else if (ctrl_cs && ctrl_ok) begin
      fptr      <= fptr + 17'd1;
      fetch_cnt <= fetch_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (cen_dec) tick_cnt <= tick_cnt + 1;
    if (dec_en) begin
      nib_q.push_back(dec_nibble);
      tick_q.push_back(tick_cnt);
      en_cnt <= en_cnt + 1;
    end
    prev_cbusy <= ctrl_busyn;
    if (prev_cbusy && !ctrl_busyn) addr_q.push_back(ctrl_addr);
    if (!sil_arm) begin
      seen_play <= 1'b0;
      sil_ticks <= 0;
    end else begin
      if (!dec_rst) seen_play <= 1'b1;
      if (seen_play && dec_rst && !busyn && cen_dec) sil_ticks <= sil_ticks + 1;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [7:0] p);
    @(posedge clk);
    #1;
    phrase = p;
    st     = 1'b1;
    @(posedge clk);
    #1;
    st     = 1'b0;
  endtask

  task automatic wait_idle(input int max_clk, input string tag);
    int n;
    n = 0;
    while (busyn !== 1'b1 && n < max_clk) begin
      step(1);
      n++;
    end
    check_val(tag, 32'(busyn), 32'd1);
  endtask

  task automatic wait_en(input int base, input int target, input int max_clk, input string tag);
    int n;
    n = 0;
    while ((en_cnt - base) < target && n < max_clk) begin
      step(1);
      n++;
    end
    check_val(tag, en_cnt - base, target);
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_busyn"},  32'(busyn), 32'd1);
    check_val({tag, "_err"},    32'(err), 32'd0);
    check_val({tag, "_cbusyn"}, 32'(ctrl_busyn), 32'd1);
    check_val({tag, "_addr"},   32'(ctrl_addr), 32'd0);
    check_val({tag, "_cs"},     32'(ctrl_cs), 32'd0);
    check_val({tag, "_decrst"}, 32'(dec_rst), 32'd1);
    check_val({tag, "_decen"},  32'(dec_en), 32'd0);
    check_val({tag, "_nib"},    32'(dec_nibble), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, n0, e0, e1, f0;
    logic [7:0] b;

    for (int i = 0; i < 1024; i++) rom[i] = 8'h00;
    rom[0]  = 8'd3;                       // max phrase N
    rom[7]  = 8'h00; rom[8]  = 8'h10;     // phrase 1 -> 0x20
    rom[9]  = 8'h00; rom[10] = 8'h20;     // phrase 2 -> 0x40
    rom[11] = 8'h00; rom[12] = 8'h30;     // phrase 3 -> 0x60
    rom[32'h20] = 8'h80; rom[32'h21] = 8'h03; rom[32'h22] = 8'h12;
    rom[32'h23] = 8'h34; rom[32'h24] = 8'h00;
    rom[32'h40] = 8'h80; rom[32'h41] = 8'h00; rom[32'h42] = 8'hAB;
    rom[32'h43] = 8'h03; rom[32'h44] = 8'h00;
    rom[32'h60] = 8'h40;
    for (int k = 0; k < 128; k++) rom[32'h61 + k] = 8'(k * 3 + 7);
    rom[32'hE1] = 8'h00;

    // reset state
    step(4);
    check_reset_vals("rst");
    rstn = 1'b1;
    step(3);

    // phrase 1: LEN play of 4 nibbles
    a0 = addr_q.size(); n0 = nib_q.size();
    start(8'd1);
    wait_idle(2000, "p1_idle");
    check_val("p1_naddr", addr_q.size() - a0, 3);
    check_val("p1_addr0", 32'(addr_q[a0]),   32'h0);
    check_val("p1_addr1", 32'(addr_q[a0+1]), 32'h7);
    check_val("p1_addr2", 32'(addr_q[a0+2]), 32'h20);
    check_val("p1_nnib",  nib_q.size() - n0, 4);
    for (int i = 0; i < 4; i++) check_val("p1_nib", 32'(nib_q[n0+i]), 32'(i + 1));
    check_val("p1_ticks", tick_q[n0+3] - tick_q[n0], 3);
    check_val("p1_err", 32'(err), 32'd0);

    // phrase 5 > N: error, no playback
    e0 = en_cnt;
    start(8'd5);
    wait_idle(20, "err_idle");
    check_val("err_flag", 32'(err), 32'd1);
    check_val("err_cbusyn", 32'(ctrl_busyn), 32'd1);
    check_val("err_cs", 32'(ctrl_cs), 32'd0);
    step(10);
    check_val("err_noen", en_cnt - e0, 0);

    // phrase 2: one nibble, then 3 silence units
    sil_arm = 1'b0;
    start(8'd2);
    check_val("p2_errclr", 32'(err), 32'd0);
    a0 = addr_q.size(); n0 = nib_q.size();
    sil_arm = 1'b1;
    wait_idle(3000, "p2_idle");
    check_val("p2_sil", sil_ticks, 96);
    check_val("p2_nnib", nib_q.size() - n0, 1);
    check_val("p2_nib", 32'(nib_q[n0]), 32'hA);
    check_val("p2_addr2", 32'(addr_q[a0+2]), 32'h40);
    sil_arm = 1'b0;

    // phrase 3: 256 nibbles with a 3-tick stall after nibble 42
    e0 = en_cnt; n0 = nib_q.size(); f0 = fetch_cnt;
    start(8'd3);
    wait_en(e0, 42, 3000, "p3_reach42");
    stall = 1'b1;
    e1 = en_cnt;
    step(24);
    check_val("p3_stall_en", en_cnt - e1, 0);
    check_val("p3_stall_cs", 32'(ctrl_cs), 32'd1);
    stall = 1'b0;
    wait_idle(5000, "p3_idle");
    check_val("p3_nen", en_cnt - e0, 256);
    check_val("p3_fetch", fetch_cnt - f0, 133);
    for (int k = 0; k < 128; k++) begin
      b = rom[32'h61 + k];
      check_val("p3_hi", 32'(nib_q[n0 + 2*k]),     32'(b[7:4]));
      check_val("p3_lo", 32'(nib_q[n0 + 2*k + 1]), 32'(b[3:0]));
    end

    // restart: phrase 2 started during phrase 1 playback
    e0 = en_cnt;
    start(8'd1);
    wait_en(e0, 1, 2000, "rs_play");
    start(8'd2);
    a0 = addr_q.size(); n0 = nib_q.size();
    check_val("rs_cs", 32'(ctrl_cs), 32'd0);
    check_val("rs_cbusyn", 32'(ctrl_busyn), 32'd1);
    check_val("rs_addr", 32'(ctrl_addr), 32'd0);
    check_val("rs_busyn", 32'(busyn), 32'd0);
    wait_idle(3000, "rs_idle");
    check_val("rs_naddr", addr_q.size() - a0, 3);
    check_val("rs_addr0", 32'(addr_q[a0]),   32'h0);
    check_val("rs_addr1", 32'(addr_q[a0+1]), 32'h9);
    check_val("rs_addr2", 32'(addr_q[a0+2]), 32'h40);
    check_val("rs_nib", 32'(nib_q[n0]), 32'hA);

    // asynchronous reset with a fetch outstanding
    e0 = en_cnt;
    start(8'd3);
    wait_en(e0, 10, 2000, "ar_play");
    stall = 1'b1;
    begin
      int n;
      n = 0;
      while (ctrl_cs !== 1'b1 && n < 200) begin
        step(1);
        n++;
      end
    end
    check_val("ar_cs_pending", 32'(ctrl_cs), 32'd1);
    #3;
    rstn = 1'b0;
    #1;
    check_reset_vals("arst");
    step(2);
    rstn = 1'b1;
    stall = 1'b0;
    e1 = en_cnt;
    step(20);
    check_reset_vals("post");
    check_val("post_noen", en_cnt - e1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
